stopwatch_ctrl: RTL and testbench

- Control FSM that sequences the stopwatch time counter datapath.
- Turns raw start/stop and lap/load buttons into counter control strobes: clear, load, count enable and direction.
- Generates the 100 Hz count-enable tick from the system clock.
- Supports count-up and count-down-from-preset modes, plus lap freeze. Sits between the board button inputs and the time counter.

---
 rtl/stopwatch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM for the stopwatch time counter datapath.
// Turns the raw start/stop and lap/load buttons into counter strobes
// (clear, load, count enable, direction) and generates the count tick.
// All outputs come from registers or registered state, so no input has a
// combinational path to an output.

module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        strtstop,
  input  logic        lap_load,
  input  logic        mode,
  input  logic [19:0] preset,
  input  logic        cnt_zero,
  output logic        cnt_ce,
  output logic        cnt_clr,
  output logic        cnt_load,
  output logic        cnt_up,
  output logic [19:0] cnt_q,
  output logic        lap_hold,
  output logic        running,
  output logic        done
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    LAP   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // bit 0 carries strtstop, bit 1 carries lap_load
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    sync3;
  logic [1:0]    btn_edge;
  logic          ss_edge;
  logic          ll_edge;

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic          ce_nxt;
  logic          clr_nxt;
  logic          zero_hit;
  logic          counting;

  // Two-flop synchroniser plus a history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {lap_load, strtstop};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign btn_edge = sync2 & ~sync3;
  assign ss_edge  = btn_edge[0];
  assign ll_edge  = btn_edge[1];

  // A countdown that has reached zero; uses the direction frozen at start
  assign zero_hit = ~cnt_up & cnt_zero;
  assign counting = (state == RUN) || (state == LAP);

  // Next-state selection; start/stop wins over lap/load in the same cycle
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_edge) begin
          if (!zero_hit) begin
            state_nxt = RUN;
          end
        end else if (ll_edge) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      RUN, LAP: begin
        if (zero_hit) begin
          state_nxt = DONE;
        end else if (ss_edge) begin
          state_nxt = PAUSE;
        end else if (ll_edge) begin
          state_nxt = (state == RUN) ? LAP : RUN;
        end
      end
      PAUSE: begin
        if (ss_edge) begin
          state_nxt = RUN;
        end else if (ll_edge) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end
      end
      DONE: begin
        if (ll_edge) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Tick phase: advances while counting, holds in PAUSE/DONE, zero in IDLE
  always_comb begin
    tick_nxt = tick_cnt;
    if (state_nxt == IDLE) begin
      tick_nxt = '0;
    end else if (counting) begin
      if (tick_cnt == TICK_LAST) begin
        tick_nxt = '0;
      end else begin
        tick_nxt = tick_cnt + TW'(1);
      end
    end
    ce_nxt = ((state_nxt == RUN) || (state_nxt == LAP)) && (tick_nxt == TICK_LAST);
  end

  // State, tick phase and strobe registers; direction and preset latch only in IDLE
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      tick_cnt <= '0;
      cnt_ce   <= 1'b0;
      cnt_clr  <= 1'b1;
      cnt_up   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      cnt_ce   <= ce_nxt;
      cnt_clr  <= clr_nxt;
      if (state == IDLE) begin
        cnt_up <= mode;
        cnt_q  <= preset;
      end
    end
  end

  assign cnt_load = (state == LOAD);
  assign running  = counting;
  assign lap_hold = (state == LAP);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl with a short tick divider.
// Expected output values are queued before each clock edge and compared
// one time unit after that edge.

module tb_stopwatch_ctrl;

  localparam int TB_DIV = 4;

  localparam int SEL_CE   = 0;
  localparam int SEL_CLR  = 1;
  localparam int SEL_LOAD = 2;
  localparam int SEL_UP   = 3;
  localparam int SEL_HOLD = 4;
  localparam int SEL_RUN  = 5;
  localparam int SEL_DONE = 6;
  localparam int SEL_Q    = 7;

  logic        clk;
  logic        clr;
  logic        strtstop;
  logic        lap_load;
  logic        mode;
  logic [19:0] preset;
  logic        cnt_zero;
  logic        cnt_ce;
  logic        cnt_clr;
  logic        cnt_load;
  logic        cnt_up;
  logic [19:0] cnt_q;
  logic        lap_hold;
  logic        running;
  logic        done;

  typedef struct {
    string       tag;
    int          sel;
    logic [19:0] val;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   ph;
  bit   cnt_st;

  stopwatch_ctrl #(.TICK_DIV(TB_DIV)) dut (
    .clk      (clk),
    .clr      (clr),
    .strtstop (strtstop),
    .lap_load (lap_load),
    .mode     (mode),
    .preset   (preset),
    .cnt_zero (cnt_zero),
    .cnt_ce   (cnt_ce),
    .cnt_clr  (cnt_clr),
    .cnt_load (cnt_load),
    .cnt_up   (cnt_up),
    .cnt_q    (cnt_q),
    .lap_hold (lap_hold),
    .running  (running),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [19:0] observe(input int sel);
    case (sel)
      SEL_CE:   return {19'b0, cnt_ce};
      SEL_CLR:  return {19'b0, cnt_clr};
      SEL_LOAD: return {19'b0, cnt_load};
      SEL_UP:   return {19'b0, cnt_up};
      SEL_HOLD: return {19'b0, lap_hold};
      SEL_RUN:  return {19'b0, running};
      SEL_DONE: return {19'b0, done};
      SEL_Q:    return cnt_q;
      default:  return 20'hFFFFF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic pushExp(input string tag, input int sel, input logic [19:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Clock once and compare everything queued for this edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sel), e.val);
    end
  endtask

  // One clock edge; nxt_cnt says whether RUN/LAP is expected after it.
  // The tick phase advances on edges taken from a counting state.
  task automatic applyStimulus(input bit nxt_cnt, input string tag);
    if (cnt_st) ph = (ph + 1) % TB_DIV;
    cnt_st = nxt_cnt;
    pushExp({tag, "_ce"}, SEL_CE, 20'(nxt_cnt && (ph == TB_DIV - 1)));
    pushExp({tag, "_run"}, SEL_RUN, 20'(nxt_cnt));
    tick();
  endtask

  // One-cycle press; the caller's next edge is the one that changes state
  task automatic pressButtons(input bit ss, input bit ll);
    strtstop = ss;
    lap_load = ll;
    applyStimulus(cnt_st, "press");
    strtstop = 1'b0;
    lap_load = 1'b0;
    applyStimulus(cnt_st, "sync");
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    ph       = 0;
    cnt_st   = 1'b0;
    clr      = 1'b1;
    strtstop = 1'b0;
    lap_load = 1'b0;
    mode     = 1'b0;
    preset   = 20'h0;
    cnt_zero = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      pushExp("rst_clr", SEL_CLR, 20'd1);
      pushExp("rst_load", SEL_LOAD, 20'd0);
      pushExp("rst_up", SEL_UP, 20'd0);
      pushExp("rst_q", SEL_Q, 20'd0);
      pushExp("rst_hold", SEL_HOLD, 20'd0);
      pushExp("rst_done", SEL_DONE, 20'd0);
      applyStimulus(1'b0, "rst");
    end
    clr = 1'b0;
    pushExp("rel_clr", SEL_CLR, 20'd0);
    pushExp("rel_up", SEL_UP, 20'd0);
    pushExp("rel_done", SEL_DONE, 20'd0);
    applyStimulus(1'b0, "rel");

    $display("[TB] count up, pause, resume");
    mode = 1'b1;
    pushExp("up_load", SEL_UP, 20'd1);
    applyStimulus(1'b0, "idle");
    pressButtons(1'b1, 1'b0);
    pushExp("start_hold", SEL_HOLD, 20'd0);
    applyStimulus(1'b1, "start");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, "run");
    pressButtons(1'b1, 1'b0);
    applyStimulus(1'b0, "pause");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, "paused");
    pressButtons(1'b1, 1'b0);
    applyStimulus(1'b1, "resume");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, "run2");

    $display("[TB] lap hold and simultaneous buttons");
    pressButtons(1'b0, 1'b1);
    pushExp("lap_hold", SEL_HOLD, 20'd1);
    applyStimulus(1'b1, "lap");
    for (int i = 0; i < 6; i++) begin
      pushExp("lap_keep", SEL_HOLD, 20'd1);
      applyStimulus(1'b1, "lapcnt");
    end
    pressButtons(1'b0, 1'b1);
    pushExp("unlap_hold", SEL_HOLD, 20'd0);
    applyStimulus(1'b1, "unlap");
    applyStimulus(1'b1, "run3");
    applyStimulus(1'b1, "run3");
    pressButtons(1'b1, 1'b1);
    pushExp("both_hold", SEL_HOLD, 20'd0);
    applyStimulus(1'b0, "both");
    for (int i = 0; i < 2; i++) begin
      pushExp("both_nolap", SEL_HOLD, 20'd0);
      applyStimulus(1'b0, "both_pause");
    end

    $display("[TB] pause to idle clear");
    pressButtons(1'b0, 1'b1);
    ph = 0;
    pushExp("pclr", SEL_CLR, 20'd1);
    applyStimulus(1'b0, "p2idle");
    pushExp("pclr_end", SEL_CLR, 20'd0);
    applyStimulus(1'b0, "idle2");

    $display("[TB] preset load");
    preset = 20'h12345;
    pushExp("q_idle", SEL_Q, 20'h12345);
    applyStimulus(1'b0, "pre");
    lap_load = 1'b1;
    applyStimulus(1'b0, "ld_a");
    lap_load = 1'b0;
    strtstop = 1'b1;
    applyStimulus(1'b0, "ld_b");
    strtstop = 1'b0;
    pushExp("load", SEL_LOAD, 20'd1);
    pushExp("load_q", SEL_Q, 20'h12345);
    applyStimulus(1'b0, "ld_c");
    pushExp("load_end", SEL_LOAD, 20'd0);
    applyStimulus(1'b0, "ld_d");
    for (int i = 0; i < 3; i++) begin
      pushExp("ld_idle_load", SEL_LOAD, 20'd0);
      applyStimulus(1'b0, "ld_idle");
    end

    $display("[TB] countdown to done");
    preset = 20'h00999;
    mode   = 1'b0;
    pushExp("up_down", SEL_UP, 20'd0);
    pushExp("q2", SEL_Q, 20'h00999);
    applyStimulus(1'b0, "cfg");
    pressButtons(1'b1, 1'b0);
    applyStimulus(1'b1, "dstart");
    preset = 20'hABCDE;
    pushExp("q_hold", SEL_Q, 20'h00999);
    applyStimulus(1'b1, "drun");
    applyStimulus(1'b1, "drun");
    cnt_zero = 1'b1;
    pushExp("done", SEL_DONE, 20'd1);
    applyStimulus(1'b0, "zero");
    pressButtons(1'b1, 1'b0);
    pushExp("done_keep", SEL_DONE, 20'd1);
    applyStimulus(1'b0, "ignore_ss");
    pushExp("done_keep2", SEL_DONE, 20'd1);
    applyStimulus(1'b0, "ignore_ss2");
    pressButtons(1'b0, 1'b1);
    ph = 0;
    pushExp("dclr", SEL_CLR, 20'd1);
    pushExp("dclr_done", SEL_DONE, 20'd0);
    applyStimulus(1'b0, "d2idle");
    pushExp("dclr_end", SEL_CLR, 20'd0);
    applyStimulus(1'b0, "idle3");

    $display("[TB] blocked start and mid-count reset");
    pressButtons(1'b1, 1'b0);
    applyStimulus(1'b0, "blocked");
    applyStimulus(1'b0, "blocked2");
    cnt_zero = 1'b0;
    pressButtons(1'b1, 1'b0);
    applyStimulus(1'b1, "go");
    applyStimulus(1'b1, "go_run");
    applyStimulus(1'b1, "go_run");
    clr = 1'b1;
    pushExp("midclr", SEL_CLR, 20'd1);
    pushExp("midclr_load", SEL_LOAD, 20'd0);
    applyStimulus(1'b0, "midclr");
    ph  = 0;
    clr = 1'b0;
    pushExp("postclr", SEL_CLR, 20'd0);
    applyStimulus(1'b0, "postclr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
